tone_sequencer: RTL and testbench

Parametrised song player that drives a square-wave `speaker` pin from a table of note words held in an external synchronous ROM. Each note word carries pitch, octave, duration in milliseconds, a rest flag and an end-of-song flag. The block sits between the top-level song ROM and the board speaker pin. It supports start/stop control, looping, rests and any clock frequency.

---
 rtl/music_pkg.sv | 29 ++
 rtl/tone_sequencer_if.sv | 11 +
 rtl/tone_divider.sv | 68 ++++++
 rtl/tone_sequencer.sv | 154 +++++++++++++++
 tb/tb_tone_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared constants and types for the tone sequencer: pitch table, note-word
// layout and FSM state encoding.
package music_pkg;

  // Octave-4 pitch frequencies in centi-Hz, C..B
  localparam int F4_CHZ [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                                 36999, 39200, 41530, 44000, 46616, 49388};

  // Field offsets above the duration field (dur_ms occupies [DUR_W-1:0])
  localparam int PITCH_OFS = 0;
  localparam int OCT_OFS   = 4;
  localparam int REST_OFS  = 7;
  localparam int END_OFS   = 8;

  localparam int GAP_MS = 10;

  typedef struct packed {
    logic        end_f;
    logic        rest;
    logic [2:0]  octave;
    logic [3:0]  pitch;
    logic [11:0] dur_ms;
  } note_word_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LOAD, ST_PLAY, ST_GAP, ST_DONE
  } state_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// Song ROM bus: address out from the sequencer, word back one cycle later.
interface tone_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DUR_W  = 12
);
  logic [ADDR_W-1:0] note_addr;
  logic [DUR_W+8:0]  note_data;

  modport master (output note_addr, input note_data);
  modport slave  (input note_addr, output note_data);
endinterface

// File: rtl/tone_divider.sv
// Half-period square-wave generator; phase restarts on clear_i, output held
// low for rests and for pitch codes 12..15.
module tone_divider
  import music_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int DIV_W  = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       rest_i,
  input  logic [3:0] pitch_i,
  input  logic [2:0] octave_i,
  output logic       speaker_o
);

  logic [63:0]      hp4;
  logic [63:0]      hp_full;
  logic [DIV_W-1:0] hp;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             spk_q, spk_d;
  logic             mute;

  assign mute = rest_i | (pitch_i > 4'd11);

  // Loop index is constant per iteration, so every division folds away
  always_comb begin
    hp4 = '0;
    for (int i = 0; i < 12; i++) begin
      if (pitch_i == 4'(i)) hp4 = (64'(CLK_HZ) * 64'd50) / 64'(F4_CHZ[i]);
    end
    if (octave_i < 3'd4) hp_full = hp4 << (3'd4 - octave_i);
    else                 hp_full = hp4 >> (octave_i - 3'd4);
    hp = DIV_W'(hp_full);
    if (hp == '0) hp = DIV_W'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    spk_d = spk_q;
    if (clear_i) begin
      cnt_d = hp - 1'b1;
      spk_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_d = hp - 1'b1;
        spk_d = ~spk_q & ~mute;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end

  assign speaker_o = spk_q;

endmodule

// File: rtl/tone_sequencer.sv
// Song player: walks note words from the song ROM and drives the speaker.
// Define TONE_SEQ_GAP_EN to insert a 10 ms silent gap after every note.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | ROM read latency
// LOAD  | decode note word
// PLAY  | tone or rest for dur_ms
// GAP   | post-note silence (TONE_SEQ_GAP_EN only)
// DONE  | one-cycle done pulse
module tone_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 24,
  parameter int DUR_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  tone_sequencer_if.master  rom,
  output logic              speaker,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  localparam int PRE_CNT = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int PRE_W   = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_CNT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DUR_W+8:0]  word_q, word_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              ms_tick;
  logic              div_clear, div_spk;

  logic [DUR_W+8:0]  cur_word;
  logic              w_end, w_rest;
  logic [2:0]        w_oct;
  logic [3:0]        w_pitch;
  logic [DUR_W-1:0]  w_dur;

  // The divider needs pitch/octave in LOAD, before word_q holds them
  assign cur_word = (state_q == ST_LOAD) ? rom.note_data : word_q;
  assign w_end    = cur_word[DUR_W+END_OFS];
  assign w_rest   = cur_word[DUR_W+REST_OFS];
  assign w_oct    = cur_word[DUR_W+OCT_OFS +: 3];
  assign w_pitch  = cur_word[DUR_W+PITCH_OFS +: 4];
  assign w_dur    = cur_word[DUR_W-1:0];
  assign ms_tick  = (pre_q == '0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    word_d    = word_q;
    dur_d     = dur_q;
    pre_d     = pre_q;
    div_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        word_d = rom.note_data;
        if (w_end) begin
          if (loop_en) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end else if (w_dur == '0) begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_FETCH;
        end else begin
          idx_d     = addr_q;
          dur_d     = w_dur;
          pre_d     = PRE_MAX;
          div_clear = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY, ST_GAP: begin
        if (ms_tick) begin
          pre_d = PRE_MAX;
          dur_d = dur_q - 1'b1;
          if (dur_q == DUR_W'(1)) begin
            state_d = ST_FETCH;
            if (state_q == ST_PLAY) begin
              addr_d = addr_q + 1'b1;
`ifdef TONE_SEQ_GAP_EN
              dur_d   = DUR_W'(GAP_MS);
              state_d = ST_GAP;
`endif
            end
          end
        end else begin
          pre_d = pre_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (stop) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      dur_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      dur_q   <= dur_d;
      pre_q   <= pre_d;
    end
  end

  tone_divider #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (div_clear),
    .en_i      (state_q == ST_PLAY),
    .rest_i    (w_rest),
    .pitch_i   (w_pitch),
    .octave_i  (w_oct),
    .speaker_o (div_spk)
  );

  assign rom.note_addr = addr_q;
  assign speaker       = div_spk & (state_q == ST_PLAY);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign note_idx      = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboarded bench for tone_sequencer at CLK_HZ = 1 MHz (1000 cycles/ms).
module tb_tone_sequencer;
  import music_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int ADDR_W = 4;
  localparam int DIV_W  = 24;
  localparam int DUR_W  = 12;
  localparam int EV_IDX = 0, EV_SPK = 1, EV_DONE = 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic speaker, busy, done;
  logic [ADDR_W-1:0] note_idx;

  tone_sequencer_if #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) rom_if ();

  tone_sequencer #(.CLK_HZ(CLK_HZ), .ADDR_W(ADDR_W), .DIV_W(DIV_W), .DUR_W(DUR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .rom      (rom_if),
    .speaker  (speaker),
    .busy     (busy),
    .done     (done),
    .note_idx (note_idx)
  );

  always #5 clk = ~clk;

  logic [DUR_W+8:0] rom_mem [2**ADDR_W];
  always @(posedge clk) rom_if.note_data <= rom_mem[rom_if.note_addr];

  typedef struct { int kind; int val; int cyc; } ev_t;
  ev_t exp_q[$];
  int  n_tests = 0, n_fail = 0, cyc = 0, exp_idx = 0;
  bit  mon_en = 1'b0;
  logic spk_prev = 1'b0;
  logic [ADDR_W-1:0] idx_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic note_word_t nw(bit e, bit r, int oct, int p, int ms);
    note_word_t w;
    w.end_f = e; w.rest = r; w.octave = 3'(oct); w.pitch = 4'(p); w.dur_ms = 12'(ms);
    return w;
  endfunction

  task automatic check(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_ev(int k, int v);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event kind=%0d val=%0d cyc=%0d", k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event got kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
                 k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (note_idx != idx_prev) check_ev(EV_IDX, int'(note_idx));
      if (speaker != spk_prev)  check_ev(EV_SPK, int'(speaker));
      if (done)                 check_ev(EV_DONE, 1);
    end
    idx_prev = note_idx;
    spk_prev = speaker;
  end

  task automatic push(int k, int v, int c);
    ev_t e;
    e.kind = k; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // p: first PLAY cycle; hp: half period (0 = silent); pin falls when PLAY ends high
  task automatic push_note(int p, int hp, int ms, int idx);
    int n, lvl;
    n = ms * 1000;
    lvl = 0;
    if (idx != exp_idx) begin
      push(EV_IDX, idx, p);
      exp_idx = idx;
    end
    if (hp > 0) begin
      for (int t = hp; t < n; t += hp) begin
        lvl ^= 1;
        push(EV_SPK, lvl, p + t);
      end
    end
    if (lvl != 0) push(EV_SPK, 0, p + n);
  endtask

  task automatic start_song(output int s);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = nw(1, 0, 0, 0, 0);
  endtask

  initial begin
    int s, p, p2, p3;
    clear_rom();
    repeat (2) @(negedge clk);
    check("rst_speaker", int'(speaker), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(rom_if.note_addr), 0);
    check("rst_idx", int'(note_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // A4 3 ms, then end
    rom_mem[0] = nw(0, 0, 4, 9, 3);
    start_song(s); p = s + 2;
    push_note(p, 1136, 3, 0);
    push(EV_DONE, 1, p + 3002);
    wait_idle(10000);
    check("a4_idle_cyc", cyc, p + 3003);
    drain();

    // A5 then A3, 3 ms each
    clear_rom();
    rom_mem[0] = nw(0, 0, 5, 9, 3);
    rom_mem[1] = nw(0, 0, 3, 9, 3);
    start_song(s); p = s + 2;
    push_note(p, 568, 3, 0);
    push_note(p + 3002, 2272, 3, 1);
    push(EV_DONE, 1, p + 6004);
    wait_idle(10000);
    check("oct_idle_cyc", cyc, p + 6005);
    drain();

    // note, 2 ms rest, note
    clear_rom();
    rom_mem[0] = nw(0, 0, 5, 9, 1);
    rom_mem[1] = nw(0, 1, 4, 9, 2);
    rom_mem[2] = nw(0, 0, 5, 9, 1);
    start_song(s); p = s + 2;
    push_note(p, 568, 1, 0);
    push_note(p + 1002, 0, 2, 1);
    push_note(p + 3004, 568, 1, 2);
    push(EV_DONE, 1, p + 4006);
    wait_cyc(p + 2002);
    check("rest_speaker", int'(speaker), 0);
    check("rest_idx", int'(note_idx), 1);
    wait_idle(10000);
    check("rest_idle_cyc", cyc, p + 4007);
    drain();

    // zero-duration note skipped, then a pitch-13 silent note
    clear_rom();
    rom_mem[0] = nw(0, 0, 5, 9, 1);
    rom_mem[1] = nw(0, 0, 4, 9, 0);
    rom_mem[2] = nw(0, 0, 5, 9, 1);
    rom_mem[3] = nw(0, 0, 4, 13, 1);
    start_song(s); p = s + 2;
    push_note(p, 568, 1, 0);
    p2 = p + 1004;
    push_note(p2, 568, 1, 2);
    p3 = p2 + 1002;
    push_note(p3, 0, 1, 3);
    push(EV_DONE, 1, p3 + 1002);
    wait_idle(10000);
    check("skip_idle_cyc", cyc, p3 + 1003);
    drain();

    // loop once, then let it finish
    clear_rom();
    rom_mem[0] = nw(0, 0, 5, 9, 1);
    loop_en = 1'b1;
    start_song(s); p = s + 2;
    push_note(p, 568, 1, 0);
    p2 = p + 1004;
    push_note(p2, 568, 1, 0);
    push(EV_DONE, 1, p2 + 1002);
    wait_cyc(p + 1002);
    check("loop_addr0", int'(rom_if.note_addr), 0);
    check("loop_busy", int'(busy), 1);
    wait_cyc(p + 1500);
    loop_en = 1'b0;
    wait_idle(10000);
    check("loop_idle_cyc", cyc, p2 + 1003);
    drain();

    // start while busy ignored; stop mid-note with speaker high
    clear_rom();
    rom_mem[0] = nw(0, 0, 4, 9, 3);
    start_song(s); p = s + 2;
    push(EV_SPK, 1, p + 1136);
    push(EV_SPK, 0, p + 1500);
    wait_cyc(p + 500);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(p + 1499);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_speaker", int'(speaker), 0);
    check("stop_done", int'(done), 0);
    drain();

    // start and stop together in IDLE
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("startstop_busy", int'(busy), 0);
    drain();

    // async reset mid-note on index 1 with speaker high
    clear_rom();
    rom_mem[0] = nw(0, 0, 5, 9, 1);
    rom_mem[1] = nw(0, 0, 4, 9, 3);
    start_song(s); p = s + 2;
    push_note(p, 568, 1, 0);
    push(EV_IDX, 1, p + 1002);
    push(EV_SPK, 1, p + 1002 + 1136);
    wait_cyc(p + 1002 + 1200);
    check("pre_reset_speaker", int'(speaker), 1);
    check("pre_reset_queue", exp_q.size(), 0);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_speaker", int'(speaker), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_idx", int'(note_idx), 0);
    check("reset_addr", int'(rom_if.note_addr), 0);
    check("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_idx = 0;
    mon_en = 1'b1;
    drain();
    check("post_reset_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
